// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational in IF, training arrives from EX, a sweep FSM invalidates entries.
module btb_predictor #(
   parameter int XLEN     = 32,
   parameter int BTB_SIZE = 64,
   parameter int CTR_BITS = 2,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lookup_valid_i,
   input  logic [XLEN-1:0]   lookup_pc_i,
   output logic              pred_hit_o,
   output logic              pred_taken_o,
   output logic [XLEN-1:0]   pred_target_o,
   input  logic              upd_valid_i,
   input  logic [XLEN-1:0]   upd_pc_i,
   input  logic [XLEN-1:0]   upd_target_i,
   input  logic              upd_taken_i,
   input  logic              upd_is_jump_i,
   input  logic              upd_mispredict_i,
   input  logic              flush_i,
   output logic              ready_o,
   output logic [PERF_W-1:0] perf_lookups_o,
   output logic [PERF_W-1:0] perf_hits_o,
   output logic [PERF_W-1:0] perf_mispredicts_o
);

   localparam int IDX   = $clog2(BTB_SIZE);
   localparam int TAG_W = XLEN - IDX - 2;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   function automatic logic [CTR_BITS-1:0] f_sat_inc(input logic [CTR_BITS-1:0] c);
      return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] f_sat_dec(input logic [CTR_BITS-1:0] c);
      return (c == '0) ? c : c - CTR_BITS'(1);
   endfunction

   state_t              r_state, w_state_nxt;
   logic [IDX-1:0]      r_idx, w_idx_nxt;
   logic                w_sweep_clr;

   logic                r_valid  [BTB_SIZE];
   logic [TAG_W-1:0]    r_tag    [BTB_SIZE];
   logic [XLEN-1:0]     r_target [BTB_SIZE];
   logic [CTR_BITS-1:0] r_ctr    [BTB_SIZE];
   logic                r_jump   [BTB_SIZE];

   logic [PERF_W-1:0]   r_lookups, r_hits, r_mispredicts;

   logic [IDX-1:0]      w_l_idx, w_u_idx;
   logic [TAG_W-1:0]    w_l_tag, w_u_tag;
   logic                w_hit, w_taken, w_upd_acc, w_u_hit, w_alloc;
   logic                w_unused;

   assign w_unused = &{1'b0, upd_pc_i[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_INIT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Flush always restarts the sweep from entry 0, even mid-sweep.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_sweep_clr = 1'b0;
      if (flush_i) begin
         w_state_nxt = S_INIT;
         w_idx_nxt   = '0;
      end else if (r_state == S_INIT) begin
         w_sweep_clr = 1'b1;
         w_idx_nxt   = r_idx + IDX'(1);
         if (r_idx == IDX'(BTB_SIZE - 1))
            w_state_nxt = S_READY;
      end
   end

   assign ready_o = (r_state == S_READY);

   assign w_l_idx = lookup_pc_i[IDX+1:2];
   assign w_l_tag = lookup_pc_i[XLEN-1:IDX+2];
   assign w_hit   = ready_o & r_valid[w_l_idx] & (r_tag[w_l_idx] == w_l_tag);
   assign w_taken = w_hit & (r_jump[w_l_idx] | r_ctr[w_l_idx][CTR_BITS-1]);

   assign pred_hit_o    = w_hit;
   assign pred_taken_o  = w_taken;
   assign pred_target_o = w_taken ? r_target[w_l_idx] : lookup_pc_i + XLEN'(4);

   assign w_u_idx   = upd_pc_i[IDX+1:2];
   assign w_u_tag   = upd_pc_i[XLEN-1:IDX+2];
   assign w_upd_acc = upd_valid_i & ready_o;
   assign w_u_hit   = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
   assign w_alloc   = w_upd_acc & ~w_u_hit & (upd_taken_i | upd_is_jump_i);

   // Sweep and updates never overlap: updates need ready_o, the sweep runs only in INIT.
   always_ff @(posedge clk) begin
      if (w_sweep_clr)
         r_valid[r_idx] <= 1'b0;
      else if (w_alloc)
         r_valid[w_u_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_upd_acc) begin
         if (w_u_hit) begin
            if (upd_is_jump_i) begin
               r_target[w_u_idx] <= upd_target_i;
               r_jump[w_u_idx]   <= 1'b1;
            end else begin
               r_ctr[w_u_idx] <= upd_taken_i ? f_sat_inc(r_ctr[w_u_idx])
                                             : f_sat_dec(r_ctr[w_u_idx]);
               if (upd_taken_i)
                  r_target[w_u_idx] <= upd_target_i;
            end
         end else if (upd_taken_i | upd_is_jump_i) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= upd_target_i;
            r_jump[w_u_idx]   <= upd_is_jump_i;
            r_ctr[w_u_idx]    <= CTR_WEAK;
         end
      end
   end

   // Performance counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lookups     <= '0;
         r_hits        <= '0;
         r_mispredicts <= '0;
      end else begin
         if (lookup_valid_i & ready_o)
            r_lookups <= r_lookups + PERF_W'(1);
         if (lookup_valid_i & w_hit)
            r_hits <= r_hits + PERF_W'(1);
         if (w_upd_acc & upd_mispredict_i)
            r_mispredicts <= r_mispredicts + PERF_W'(1);
      end
   end

   assign perf_lookups_o     = r_lookups;
   assign perf_hits_o        = r_hits;
   assign perf_mispredicts_o = r_mispredicts;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: sweep timing, training, aliasing, same-cycle
// lookup/update, flush restart and performance counters.
module tb_btb_predictor;

   localparam int XLEN     = 32;
   localparam int BTB_SIZE = 64;
   localparam int CTR_BITS = 2;
   localparam int PERF_W   = 32;

   logic              clk;
   logic              rst_n;
   logic              lookup_valid_i;
   logic [XLEN-1:0]   lookup_pc_i;
   logic              pred_hit_o;
   logic              pred_taken_o;
   logic [XLEN-1:0]   pred_target_o;
   logic              upd_valid_i;
   logic [XLEN-1:0]   upd_pc_i;
   logic [XLEN-1:0]   upd_target_i;
   logic              upd_taken_i;
   logic              upd_is_jump_i;
   logic              upd_mispredict_i;
   logic              flush_i;
   logic              ready_o;
   logic [PERF_W-1:0] perf_lookups_o;
   logic [PERF_W-1:0] perf_hits_o;
   logic [PERF_W-1:0] perf_mispredicts_o;

   int tests  = 0;
   int failed = 0;

   btb_predictor #(
      .XLEN(XLEN), .BTB_SIZE(BTB_SIZE), .CTR_BITS(CTR_BITS), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
      .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
      .upd_taken_i(upd_taken_i), .upd_is_jump_i(upd_is_jump_i),
      .upd_mispredict_i(upd_mispredict_i), .flush_i(flush_i), .ready_o(ready_o),
      .perf_lookups_o(perf_lookups_o), .perf_hits_o(perf_hits_o),
      .perf_mispredicts_o(perf_mispredicts_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                      input logic tk, input logic jp, input logic mp);
      upd_valid_i      = 1'b1;
      upd_pc_i         = pc;
      upd_target_i     = tgt;
      upd_taken_i      = tk;
      upd_is_jump_i    = jp;
      upd_mispredict_i = mp;
      tick();
      upd_valid_i      = 1'b0;
      upd_mispredict_i = 1'b0;
   endtask

   task automatic look(input string tag, input logic [XLEN-1:0] pc,
                       input logic eh, input logic et, input logic [XLEN-1:0] etg);
      lookup_valid_i = 1'b1;
      lookup_pc_i    = pc;
      #1;
      check({tag, ".hit"},    64'(pred_hit_o),    64'(eh));
      check({tag, ".taken"},  64'(pred_taken_o),  64'(et));
      check({tag, ".target"}, 64'(pred_target_o), 64'(etg));
      tick();
      lookup_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int exp_n);
      int n = 0;
      while (!ready_o && n < 200) begin
         tick();
         n++;
      end
      check(tag, 64'(n), 64'(exp_n));
   endtask

   initial begin
      rst_n            = 1'b0;
      lookup_valid_i   = 1'b0;
      lookup_pc_i      = 32'h100;
      upd_valid_i      = 1'b0;
      upd_pc_i         = '0;
      upd_target_i     = '0;
      upd_taken_i      = 1'b0;
      upd_is_jump_i    = 1'b0;
      upd_mispredict_i = 1'b0;
      flush_i          = 1'b0;
      tick();
      tick();
      check("rst.ready",   64'(ready_o),            64'(0));
      check("rst.lookups", 64'(perf_lookups_o),     64'(0));
      check("rst.hits",    64'(perf_hits_o),        64'(0));
      check("rst.mispred", 64'(perf_mispredicts_o), 64'(0));
      check("rst.hit",     64'(pred_hit_o),         64'(0));
      check("rst.target",  64'(pred_target_o),      64'(32'h104));

      // Sweep after reset, with a lookup held active throughout
      rst_n          = 1'b1;
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 32'h100;
      #1;
      check("init.hit",    64'(pred_hit_o),    64'(0));
      check("init.taken",  64'(pred_taken_o),  64'(0));
      check("init.target", 64'(pred_target_o), 64'(32'h104));
      wait_ready("init.edges", 64);
      lookup_valid_i = 1'b0;
      check("init.lookups", 64'(perf_lookups_o), 64'(0));

      // Allocate, then weaken
      upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
      look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
      look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);

      // Saturation: ctr 1 -> 2, then four taken saturate at 3
      upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
      repeat (4) upd(32'h100, 32'h240, 1'b1, 1'b0, 1'b0);
      look("sat3", 32'h100, 1'b1, 1'b1, 32'h240);
      upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      look("sat2", 32'h100, 1'b1, 1'b1, 32'h240);
      upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      look("sat1", 32'h100, 1'b1, 1'b0, 32'h104);

      // Jump entry stays taken regardless of the counter
      upd(32'h104, 32'h800, 1'b1, 1'b1, 1'b0);
      repeat (3) upd(32'h104, 32'h0, 1'b0, 1'b0, 1'b0);
      look("jump", 32'h104, 1'b1, 1'b1, 32'h800);

      // Alias at the same index with a different tag
      look("alias", 32'h200, 1'b0, 1'b0, 32'h204);
      upd(32'h200, 32'h555, 1'b0, 1'b0, 1'b0);
      look("alias.keep", 32'h100, 1'b1, 1'b0, 32'h104);

      // Same-cycle lookup and allocating update
      lookup_valid_i   = 1'b1;
      lookup_pc_i      = 32'h300;
      upd_valid_i      = 1'b1;
      upd_pc_i         = 32'h300;
      upd_target_i     = 32'h700;
      upd_taken_i      = 1'b1;
      upd_is_jump_i    = 1'b0;
      upd_mispredict_i = 1'b1;
      #1;
      check("same.hit0",    64'(pred_hit_o),    64'(0));
      check("same.target0", 64'(pred_target_o), 64'(32'h304));
      tick();
      upd_valid_i      = 1'b0;
      upd_mispredict_i = 1'b0;
      #1;
      check("same.hit1",    64'(pred_hit_o),    64'(1));
      check("same.target1", 64'(pred_target_o), 64'(32'h700));
      tick();
      lookup_valid_i = 1'b0;
      check("perf.lookups", 64'(perf_lookups_o),     64'(10));
      check("perf.hits",    64'(perf_hits_o),        64'(8));
      check("perf.mispred", 64'(perf_mispredicts_o), 64'(2));

      // Flush from READY, then re-flush at sweep index 30 with traffic active
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush.ready", 64'(ready_o), 64'(0));
      lookup_valid_i   = 1'b1;
      lookup_pc_i      = 32'h100;
      upd_valid_i      = 1'b1;
      upd_pc_i         = 32'h400;
      upd_target_i     = 32'h900;
      upd_taken_i      = 1'b1;
      upd_mispredict_i = 1'b1;
      repeat (30) tick();
      check("flush.hit", 64'(pred_hit_o), 64'(0));
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      wait_ready("reflush.edges", 64);
      lookup_valid_i   = 1'b0;
      upd_valid_i      = 1'b0;
      upd_mispredict_i = 1'b0;
      check("flush.lookups", 64'(perf_lookups_o),     64'(10));
      check("flush.hits",    64'(perf_hits_o),        64'(8));
      check("flush.mispred", 64'(perf_mispredicts_o), 64'(2));
      look("post.100", 32'h100, 1'b0, 1'b0, 32'h104);
      look("post.104", 32'h104, 1'b0, 1'b0, 32'h108);
      look("post.400", 32'h400, 1'b0, 1'b0, 32'h404);
      look("post.300", 32'h300, 1'b0, 1'b0, 32'h304);
      check("post.lookups", 64'(perf_lookups_o), 64'(14));
      check("post.hits",    64'(perf_hits_o),    64'(8));
      upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b1);
      check("post.mispred", 64'(perf_mispredicts_o), 64'(3));
      look("post.nowrite", 32'h100, 1'b0, 1'b0, 32'h104);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Lives in IF: same-cycle target/direction prediction from the fetch PC.
- Trained from EX on branch/jump resolution.
- Invalidated by a sequential sweep FSM after reset or flush; counts lookups, hits and mispredicts for perf.

Parameters:
XLEN, 32, address/data width
BTB_SIZE, 64, number of entries (power of two, >=2)
CTR_BITS, 2, direction counter width (>=1)
PERF_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
lookup_valid_i  in  1  fetch PC valid this cycle
lookup_pc_i  in  XLEN  fetch PC
pred_hit_o  out  1  tag hit on valid entry
pred_taken_o  out  1  predicted taken
pred_target_o  out  XLEN  predicted next PC
upd_valid_i  in  1  resolution update strobe
upd_pc_i  in  XLEN  PC of resolved control instruction
upd_target_i  in  XLEN  resolved target
upd_taken_i  in  1  resolved direction
upd_is_jump_i  in  1  JAL/JALR (unconditional)
upd_mispredict_i  in  1  resolution disagreed with prediction
flush_i  in  1  invalidate all entries
ready_o  out  1  sweep complete, predictions enabled
perf_lookups_o  out  PERF_W  qualified lookups
perf_hits_o  out  PERF_W  qualified hits
perf_mispredicts_o  out  PERF_W  mispredict updates

Behaviour:
- Index = pc[IDX+1:2] with IDX = log2(BTB_SIZE). Tag = pc[XLEN-1:IDX+2]. pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[CTR_BITS-1:0], is_jump. Only valid is cleared; the other arrays have no reset.
- FSM states: INIT and READY.
  - Reset (rst_n=0 at a clk edge): state=INIT, sweep idx=0, all perf counters=0.
  - INIT: each edge clears valid[idx] and increments idx. The edge that clears idx=BTB_SIZE-1 moves to READY.
  - ready_o=1 exactly BTB_SIZE edges after reset deasserts.
  - flush_i=1 in any state forces INIT with idx=0. A flush during INIT restarts the sweep.
  - Reset has priority over flush.
- ready_o = (state==READY). Reset value 0.
- Lookup is combinational from array state; no bypass of a same-cycle update.
  - hit = ready_o & valid & tag match.
  - pred_hit_o = hit.
  - pred_taken_o = hit & (is_jump | ctr[MSB]).
  - pred_target_o = pred_taken_o ? entry target : lookup_pc_i+4, mod 2^XLEN.
  - During INIT and reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=pc+4.
- Update is accepted only when upd_valid_i & ready_o; otherwise it is dropped. It writes at the clock edge.
  - Hit, conditional branch: taken → ctr saturating increment (max 2^CTR_BITS-1); not taken → saturating decrement (min 0). Target overwritten only if taken.
  - Hit, jump: target overwritten, is_jump=1.
  - Miss (invalid or tag mismatch): allocate/replace only if upd_taken_i|upd_is_jump_i. Allocation writes valid=1, tag, target, is_jump, ctr=2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no write.
- Perf counters wrap modulo 2^PERF_W.
  - lookups +1 when lookup_valid_i & ready_o.
  - hits +1 when lookup_valid_i & hit.
  - mispredicts +1 when accepted update & upd_mispredict_i.
  - Counters are not cleared by flush.
- Lookup and update on the same index in the same cycle: lookup returns the pre-update entry; the update commits.

Test Plan:
- BTB_SIZE=64: release reset → ready_o=0 for 64 cycles, 1 on the 64th edge. A lookup at 0x100 during the sweep → hit=0, target=0x104, perf_lookups stays 0.
- Update pc=0x100, target=0x200, taken=1 → next-cycle lookup 0x100 gives hit=1, taken=1, target=0x200, ctr=2. A not-taken update → ctr=1, taken=0, target=0x104.
- Four taken updates from ctr=2 → ctr saturates at 3. Two not-taken → ctr=1, taken=0. Jump entry with not-taken updates → still taken=1.
- Alias: pc=0x100 allocated; lookup 0x200 (same index for SIZE=64) → hit=0. Not-taken update at 0x200 → entry for 0x100 is unchanged.
- Same-cycle lookup and allocating update at 0x300 → that cycle hit=0, next cycle hit=1.
- flush_i at sweep idx=30 → sweep restarts and ready_o rises 64 edges later. All prior entries miss; perf counters keep their values. Updates during the sweep are dropped.
